fifo_stream_reader: RTL and testbench

Read-side master for sync_fifo. It drains the FIFO through its rd_en/empty/valid/dout interface and presents the words as a valid/ready stream to the downstream consumer. It supports both FIFO_TYPE variants ("Standard": data one cycle after rd_en; "FWFT": head word visible while !empty). A 3-slot internal buffer absorbs read latency, so it sustains 1 word/clk with no combinational path from m_ready to fifo_rd_en.

---
 rtl/fifo_stream_pkg.sv | 14 +
 rtl/stream_skid_buf.sv | 56 +++++
 rtl/fifo_stream_reader.sv | 81 ++++++++
 tb/tb_fifo_stream_reader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the sync_fifo read-side stream master.
package fifo_stream_pkg;

  localparam int BUF_SLOTS = 3;

  typedef logic [1:0] slot_ptr_t;
  typedef logic [1:0] occ_t;

  // Advance a slot pointer, wrapping from the last slot back to slot 0.
  function automatic slot_ptr_t next_ptr(input slot_ptr_t p);
    return (p == slot_ptr_t'(BUF_SLOTS - 1)) ? '0 : p + slot_ptr_t'(1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Three-slot register ring that absorbs the FIFO read latency and
// presents its oldest word as a valid/ready stream.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] slots [BUF_SLOTS];
  slot_ptr_t             head;
  slot_ptr_t             tail;
  logic                  accept;

  // Stream side: the head slot is offered whenever anything is buffered.
  assign m_valid = !rst && (occ != occ_t'(0));
  assign m_data  = slots[head];
  assign accept  = m_valid && m_ready;

  // Pointer and occupancy bookkeeping; a write and an accept together leave occ unchanged.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (wr_en)  tail <= next_ptr(tail);
      if (accept) head <= next_ptr(head);
      unique case ({wr_en, accept})
        2'b10:   occ <= occ + occ_t'(1);
        2'b01:   occ <= occ - occ_t'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Data slots; only ever read when occ marks them as holding a word.
  always_ff @(posedge clk) begin
    // NOTE: the slot storage is deliberately not reset; occ alone decides what is valid.
    if (wr_en) slots[tail] <= wr_data;
  end

  // The issue logic keeps occ + pend <= 3, so a write can never land on a full ring.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(wr_en && (occ == occ_t'(BUF_SLOTS))));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for sync_fifo: issues rd_en, captures returned words
// into a 3-slot buffer and streams them out at up to one word per clock.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter string FIFO_TYPE  = "Standard",
  parameter int    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  err_unexp
);

  localparam bit IS_FWFT = (FIFO_TYPE == "FWFT");

  if (FIFO_TYPE != "Standard" && FIFO_TYPE != "FWFT") begin : g_bad_type
    $fatal(1, "fifo_stream_reader: unsupported FIFO_TYPE %s", FIFO_TYPE);
  end

  occ_t       occ;
  logic       pend;      // Standard mode: a read was issued last cycle, data due now
  logic       post_rst;  // first cycle after reset: stray fifo_valid is not an error
  logic [2:0] occ_pend;
  logic       buf_wr;
  logic       unexp;

  // Issue and capture decisions; rd_en looks only at registered state and fifo_empty.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    fifo_rd_en = 1'b0;
    buf_wr     = 1'b0;
    unexp      = 1'b0;
    occ_pend   = {1'b0, occ} + {2'b00, pend};
    if (IS_FWFT) begin
      fifo_rd_en = !rst && !fifo_empty && ({1'b0, occ} < 3'(BUF_SLOTS));
      buf_wr     = fifo_rd_en;
    end else begin
      fifo_rd_en = !rst && !fifo_empty && (occ_pend < 3'(BUF_SLOTS));
      buf_wr     = fifo_valid && pend;
      unexp      = fifo_valid && !pend && !post_rst;
    end
  end

  // Read-outstanding flag, sticky error and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= 1'b0;
      post_rst   <= 1'b1;
      err_unexp  <= 1'b0;
      xfer_count <= '0;
    end else begin
      pend     <= IS_FWFT ? 1'b0 : fifo_rd_en;
      post_rst <= 1'b0;
      if (unexp)              err_unexp  <= 1'b1;
      if (m_valid && m_ready) xfer_count <= xfer_count + CNT_WIDTH'(1);
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data (fifo_dout),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .occ     (occ)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: one Standard and one FWFT instance, each fed by
// a small behavioural sync_fifo model of depth 4.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          clr = 1'b1;
  logic [1:0]    wr_req = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0]    m_ready = '0;
  logic          inj_valid = 1'b0;
  logic [DW-1:0] inj_data = '0;
  logic          mode = 1'b0;

  // FIFO models: index 0 Standard, index 1 FWFT
  logic [DW-1:0] mem [2][FD];
  logic [1:0]    wp [2];
  logic [1:0]    rp [2];
  logic [2:0]    lvl [2];
  logic [DW-1:0] dout_s;
  logic          valid_s;

  logic          rd_s, rd_f, mv_s, mv_f, err_s, err_f;
  logic [DW-1:0] md_s, md_f;
  logic [CW-1:0] cnt_s, cnt_f;

  wire [1:0] do_rd = {rd_f && (lvl[1] != 3'd0), rd_s && (lvl[0] != 3'd0)};
  wire [1:0] do_wr = {wr_req[1] && (lvl[1] != 3'(FD)), wr_req[0] && (lvl[0] != 3'(FD))};

  wire          empty_s    = (lvl[0] == 3'd0);
  wire          empty_f    = (lvl[1] == 3'd0);
  wire          fvalid_s   = valid_s | inj_valid;
  wire [DW-1:0] fdout_s    = inj_valid ? inj_data : dout_s;
  wire [DW-1:0] fdout_f    = mem[1][rp[1]];

  always @(posedge clk) begin
    if (clr) begin
      for (int m = 0; m < 2; m++) begin
        wp[m]  <= '0;
        rp[m]  <= '0;
        lvl[m] <= '0;
      end
      valid_s <= 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (do_wr[m]) begin
          mem[m][wp[m]] <= wr_data;
          wp[m]         <= wp[m] + 2'd1;
        end
        if (do_rd[m]) rp[m] <= rp[m] + 2'd1;
        lvl[m] <= lvl[m] + 3'(do_wr[m]) - 3'(do_rd[m]);
      end
      valid_s <= do_rd[0];
      if (do_rd[0]) dout_s <= mem[0][rp[0]];
    end
  end

  fifo_stream_reader #(.DATA_WIDTH(DW), .FIFO_TYPE("Standard"), .CNT_WIDTH(CW)) dut_std (
    .clk(clk), .rst(rst), .fifo_empty(empty_s), .fifo_valid(fvalid_s), .fifo_dout(fdout_s),
    .fifo_rd_en(rd_s), .m_valid(mv_s), .m_ready(m_ready[0]), .m_data(md_s),
    .xfer_count(cnt_s), .err_unexp(err_s));

  fifo_stream_reader #(.DATA_WIDTH(DW), .FIFO_TYPE("FWFT"), .CNT_WIDTH(CW)) dut_fwft (
    .clk(clk), .rst(rst), .fifo_empty(empty_f), .fifo_valid(!empty_f), .fifo_dout(fdout_f),
    .fifo_rd_en(rd_f), .m_valid(mv_f), .m_ready(m_ready[1]), .m_data(md_f),
    .xfer_count(cnt_f), .err_unexp(err_f));

  wire          cur_rd  = mode ? rd_f  : rd_s;
  wire          cur_mv  = mode ? mv_f  : mv_s;
  wire [DW-1:0] cur_md  = mode ? md_f  : md_s;
  wire [CW-1:0] cur_cnt = mode ? cnt_f : cnt_s;
  wire          cur_err = mode ? err_f : err_s;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          mode;
    logic          rdy;
    logic          rd;
    logic          v;
    logic [DW-1:0] d;
    logic [CW-1:0] cnt;
    int            lvl;   // -1: do not check FIFO level
  } vec_t;

  vec_t vec [28];

  // Hold both readers in reset, empty both models, then load n words into one model.
  task automatic preload(input logic m, input int n, input int base, input int step);
    @(negedge clk);
    rst = 1'b1; clr = 1'b1; wr_req = '0; inj_valid = 1'b0; mode = m;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_req[m] = 1'b1;
      wr_data   = DW'(base + i * step);
      @(negedge clk);
    end
    wr_req = '0;
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      rst = 1'b0;
      mode = vec[i].mode;
      m_ready[vec[i].mode] = vec[i].rdy;
      #1;
      check($sformatf("row%0d rd_en", i), cur_rd, vec[i].rd);
      check($sformatf("row%0d m_valid", i), cur_mv, vec[i].v);
      if (vec[i].v) check($sformatf("row%0d m_data", i), cur_md, vec[i].d);
      check($sformatf("row%0d xfer_count", i), cur_cnt, vec[i].cnt);
      if (vec[i].lvl >= 0) check($sformatf("row%0d fifo level", i), lvl[vec[i].mode], vec[i].lvl);
    end
  endtask

  logic [DW-1:0] exp_q [$];

  task automatic writer(input int n);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (lvl[mode] != 3'(FD) && $urandom_range(0, 3) != 0) begin
        wr_req[mode] = 1'b1;
        wr_data = DW'($urandom);
        exp_q.push_back(wr_data);
        i++;
      end else begin
        wr_req[mode] = 1'b0;
      end
    end
    @(negedge clk);
    wr_req = '0;
    check("writer finished", i, n);
  endtask

  task automatic reader(input int n);
    int beats = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    while (beats < n && cyc < 8000) begin
      @(negedge clk);
      m_ready[mode] = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (prev_stall) check("stall hold", {23'd0, cur_mv, cur_md}, {23'd0, 1'b1, prev_d});
      if (cur_mv && m_ready[mode]) begin
        if (exp_q.size() == 0) check("beat without word", cur_md, 32'hFFFF_FFFF);
        else check("beat data", cur_md, exp_q.pop_front());
        beats++;
      end
      prev_stall = cur_mv && !m_ready[mode];
      prev_d     = cur_md;
    end
    check("beats delivered", beats, n);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: Standard, 4 words, m_ready=1 (first m_valid 2 clk after first rd_en)
    vec[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0, -1};
    vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0, -1};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 16'd0, -1};
    vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 16'd1, -1};
    vec[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 16'd2, -1};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 16'd3, -1};
    vec[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd4, -1};
    // Test 2: FWFT, same data (first m_valid 1 clk after first rd_en)
    vec[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0, -1};
    vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 16'd0, -1};
    vec[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 16'd1, -1};
    vec[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 16'd2, -1};
    vec[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 16'd3, -1};
    vec[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd4, -1};
    // Test 3: Standard backpressure, A0..A3, m_ready=0 for 10 clk
    vec[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0, -1};
    vec[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0, -1};
    vec[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 16'd0, -1};
    vec[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd0, -1};
    vec[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd0, -1};
    vec[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd0, -1};
    vec[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd0, -1};
    vec[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd0, -1};
    vec[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd0, -1};
    vec[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd0,  1};
    vec[23] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 16'd0, -1};
    vec[24] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 16'd1, -1};
    vec[25] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA2, 16'd2, -1};
    vec[26] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 16'd3, -1};
    vec[27] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd4, -1};

    repeat (3) @(negedge clk);

    // Reset state
    #1;
    check("reset rd_en std", rd_s, 1'b0);
    check("reset m_valid std", mv_s, 1'b0);
    check("reset m_valid fwft", mv_f, 1'b0);
    check("reset xfer_count std", cnt_s, 16'd0);
    check("reset err_unexp std", err_s, 1'b0);

    preload(1'b0, 4, 8'h11, 8'h11);
    run_rows(0, 6);
    check("t1 err_unexp", err_s, 1'b0);

    preload(1'b1, 4, 8'h11, 8'h11);
    run_rows(7, 12);
    check("t2 err_unexp", err_f, 1'b0);

    preload(1'b0, 4, 8'hA0, 1);
    run_rows(13, 27);

    // Test 4: unexpected fifo_valid with nothing outstanding
    @(negedge clk);
    inj_valid = 1'b1; inj_data = 8'h99;
    @(negedge clk);
    inj_valid = 1'b0;
    #1;
    check("t4 err_unexp set", err_s, 1'b1);
    check("t4 no beat", mv_s, 1'b0);
    check("t4 xfer_count unchanged", cnt_s, 16'd4);
    repeat (3) @(negedge clk);
    #1;
    check("t4 err_unexp sticky", err_s, 1'b1);
    check("t4 still no beat", mv_s, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t4 err_unexp cleared", err_s, 1'b0);
    check("t4 xfer_count cleared", cnt_s, 16'd0);
    check("t4 rd_en in reset", rd_s, 1'b0);

    // Test 5: reset in the cycle after a rd_en; stray valid right after release
    preload(1'b0, 1, 8'h55, 0);
    @(negedge clk);
    rst = 1'b0; m_ready[0] = 1'b1;
    #1;
    check("t5 rd_en issued", rd_s, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5 rd_en gated by rst", rd_s, 1'b0);
    check("t5 m_valid gated by rst", mv_s, 1'b0);
    check("t5 fifo returned word", fvalid_s, 1'b1);
    @(negedge clk);
    rst = 1'b0; inj_valid = 1'b1; inj_data = 8'h66;
    #1;
    check("t5 no rd_en after reset", rd_s, 1'b0);
    @(negedge clk);
    inj_valid = 1'b0;
    #1;
    check("t5 err_unexp clear", err_s, 1'b0);
    check("t5 m_valid low", mv_s, 1'b0);
    check("t5 xfer_count zero", cnt_s, 16'd0);
    @(negedge clk);
    #1;
    check("t5 m_valid still low", mv_s, 1'b0);
    check("t5 err_unexp still clear", err_s, 1'b0);

    // Test 6: random traffic with random m_ready, both modes
    for (int m = 0; m < 2; m++) begin
      preload(1'(m), 0, 0, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      fork
        writer(300);
        reader(300);
      join
      @(negedge clk);
      m_ready = '0;
      #1;
      check($sformatf("t6 mode%0d xfer_count", m), cur_cnt, 16'(300));
      check($sformatf("t6 mode%0d err_unexp", m), cur_err, 1'b0);
      check($sformatf("t6 mode%0d leftover words", m), exp_q.size(), 0);
      check($sformatf("t6 mode%0d drained", m), cur_mv, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
